// File: rtl/pe_mac_lanes.sv
// rtl/pe_mac_lanes.sv - LANES-wide signed MAC processing element with saturating valid/ready output
module pe_mac_lanes #(
  parameter int FEATURE_WD = 8,
  parameter int WEIGHT_WD  = 8,
  parameter int LANES      = 4,
  parameter int ACC_WD     = 24,
  parameter int OUT_WD     = 18
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          clr_i,
  input  logic [ACC_WD-1:0]             bias_i,
  input  logic [LANES*FEATURE_WD-1:0]   feat_i,
  input  logic [LANES*WEIGHT_WD-1:0]    wgt_i,
  input  logic [LANES-1:0]              lane_msk_i,
  input  logic                          feat_signed_i,
  input  logic                          pe_col_vld,
  input  logic                          pe_row_vld,
  input  logic                          pe_array_vld,
  input  logic                          last_i,
  output logic                          busy_o,
  output logic [OUT_WD-1:0]             out_data_o,
  output logic                          out_vld_o,
  input  logic                          out_rdy_i,
  output logic                          sat_flag_o
);

  // One extra bit holds an unsigned feature as a positive signed value.
  localparam int PROD_WD = FEATURE_WD + WEIGHT_WD + 1;
  localparam int SUM_WD  = PROD_WD + $clog2(LANES);
  localparam int EXT_WD  = ACC_WD + 1;

  localparam logic signed [ACC_WD-1:0] ACC_MAX = {1'b0, {(ACC_WD-1){1'b1}}};
  localparam logic signed [ACC_WD-1:0] ACC_MIN = {1'b1, {(ACC_WD-1){1'b0}}};
  localparam logic signed [OUT_WD-1:0] OUT_MAX = {1'b0, {(OUT_WD-1){1'b1}}};
  localparam logic signed [OUT_WD-1:0] OUT_MIN = {1'b1, {(OUT_WD-1){1'b0}}};

  typedef enum logic {ST_ACC, ST_HOLD} state_t;

  state_t                    state;
  logic signed [ACC_WD-1:0]  acc;
  logic                      acc_sat;
  logic                      s1_vld;
  logic                      s1_last;
  logic signed [SUM_WD-1:0]  s1_sum;
  logic signed [SUM_WD-1:0]  lane_sum;
  logic signed [PROD_WD-1:0] prod [LANES];
  logic                      accept;

  logic signed [EXT_WD-1:0]  acc_raw;
  logic signed [ACC_WD-1:0]  acc_nxt;
  logic                      acc_clip;
  logic signed [OUT_WD-1:0]  out_nxt;
  logic                      out_clip;

  assign busy_o = (state == ST_HOLD) | (s1_vld & s1_last);
  assign accept = pe_col_vld & pe_row_vld & pe_array_vld & ~busy_o & ~clr_i;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic signed [PROD_WD-1:0] fx;
    logic signed [PROD_WD-1:0] wx;
    assign fx = feat_signed_i ? PROD_WD'(signed'(feat_i[k*FEATURE_WD +: FEATURE_WD]))
                              : PROD_WD'(feat_i[k*FEATURE_WD +: FEATURE_WD]);
    assign wx = PROD_WD'(signed'(wgt_i[k*WEIGHT_WD +: WEIGHT_WD]));
    assign prod[k] = lane_msk_i[k] ? fx * wx : '0;
  end

  // Adder tree over the masked lane products feeding stage 1.
  always_comb begin
    lane_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + SUM_WD'(prod[k]);
    end
  end

  // Saturating accumulate and output clip of the stage-2 result.
  always_comb begin
    acc_raw  = EXT_WD'(acc) + EXT_WD'(s1_sum);
    acc_clip = acc_raw[EXT_WD-1] ^ acc_raw[EXT_WD-2];
    if (acc_clip) begin
      acc_nxt = acc_raw[EXT_WD-1] ? ACC_MIN : ACC_MAX;
    end else begin
      acc_nxt = acc_raw[ACC_WD-1:0];
    end
    out_clip = ~((&acc_nxt[ACC_WD-1:OUT_WD-1]) | ~(|acc_nxt[ACC_WD-1:OUT_WD-1]));
    if (out_clip) begin
      out_nxt = acc_nxt[ACC_WD-1] ? OUT_MIN : OUT_MAX;
    end else begin
      out_nxt = acc_nxt[OUT_WD-1:0];
    end
  end

  // Pipeline, accumulator and ACC/HOLD control; clear overrides everything but reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_ACC;
      acc        <= '0;
      acc_sat    <= 1'b0;
      s1_vld     <= 1'b0;
      s1_last    <= 1'b0;
      s1_sum     <= '0;
      out_data_o <= '0;
      out_vld_o  <= 1'b0;
      sat_flag_o <= 1'b0;
    end else if (clr_i) begin
      state      <= ST_ACC;
      acc        <= bias_i;
      acc_sat    <= 1'b0;
      s1_vld     <= 1'b0;
      out_vld_o  <= 1'b0;
      sat_flag_o <= 1'b0;
    end else begin
      s1_vld  <= accept;
      s1_last <= accept & last_i;
      if (accept) begin
        s1_sum <= lane_sum;
      end
      case (state)
        ST_ACC: begin
          if (s1_vld) begin
            acc     <= acc_nxt;
            acc_sat <= acc_sat | acc_clip;
          end
          if (s1_vld & s1_last) begin
            out_data_o <= out_nxt;
            out_vld_o  <= 1'b1;
            sat_flag_o <= acc_sat | acc_clip | out_clip;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_vld_o & out_rdy_i) begin
            out_vld_o <= 1'b0;
            acc       <= '0;
            acc_sat   <= 1'b0;
            state     <= ST_ACC;
          end
        end
        default: state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_mac_lanes.sv
// tb/tb_pe_mac_lanes.sv - scoreboard bench for pe_mac_lanes
module tb_pe_mac_lanes;
  localparam int FW = 8;
  localparam int WW = 8;
  localparam int LN = 4;
  localparam int AW = 24;
  localparam int OW = 18;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             clr_i = 1'b0;
  logic [AW-1:0]    bias_i = '0;
  logic [LN*FW-1:0] feat_i = '0;
  logic [LN*WW-1:0] wgt_i = '0;
  logic [LN-1:0]    lane_msk_i = '0;
  logic             feat_signed_i = 1'b0;
  logic             pe_col_vld = 1'b0;
  logic             pe_row_vld = 1'b0;
  logic             pe_array_vld = 1'b0;
  logic             last_i = 1'b0;
  logic             out_rdy_i = 1'b0;
  logic             busy_o;
  logic [OW-1:0]    out_data_o;
  logic             out_vld_o;
  logic             sat_flag_o;

  always #5 clk = ~clk;

  pe_mac_lanes #(
    .FEATURE_WD(FW), .WEIGHT_WD(WW), .LANES(LN), .ACC_WD(AW), .OUT_WD(OW)
  ) dut (
    .clk(clk), .rstn(rstn), .clr_i(clr_i), .bias_i(bias_i), .feat_i(feat_i),
    .wgt_i(wgt_i), .lane_msk_i(lane_msk_i), .feat_signed_i(feat_signed_i),
    .pe_col_vld(pe_col_vld), .pe_row_vld(pe_row_vld), .pe_array_vld(pe_array_vld),
    .last_i(last_i), .busy_o(busy_o), .out_data_o(out_data_o), .out_vld_o(out_vld_o),
    .out_rdy_i(out_rdy_i), .sat_flag_o(sat_flag_o)
  );

  typedef struct {longint data; bit sat;} exp_t;

  int     n_assert = 0;
  int     n_fail = 0;
  exp_t   sb[$];
  longint m_acc = 0;
  bit     m_sat = 0;

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint clamp(input longint v, input int wd);
    longint hi;
    longint lo;
    hi = (longint'(1) << (wd - 1)) - 1;
    lo = -(longint'(1) << (wd - 1));
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic longint beat_sum(input logic [31:0] f, input logic [31:0] w,
                                      input logic [3:0] m, input bit sg);
    longint s;
    longint fv;
    logic [7:0] fb;
    logic [7:0] wb;
    s = 0;
    for (int k = 0; k < LN; k++) begin
      if (m[k]) begin
        fb = f[k*8 +: 8];
        wb = w[k*8 +: 8];
        fv = sg ? longint'(signed'(fb)) : longint'(fb);
        s = s + fv * longint'(signed'(wb));
      end
    end
    return s;
  endfunction

  task automatic set_vld(input bit v);
    pe_col_vld = v;
    pe_row_vld = v;
    pe_array_vld = v;
  endtask

  task automatic do_clr(input longint b);
    clr_i = 1'b1;
    bias_i = b[AW-1:0];
    @(posedge clk); #1;
    clr_i = 1'b0;
    m_acc = b;
    m_sat = 0;
    check("clr_vld_low", out_vld_o, 0);
  endtask

  task automatic send(input logic [31:0] f, input logic [31:0] w, input logic [3:0] m,
                      input bit sg, input bit lst);
    longint raw;
    longint o;
    check("busy_before_beat", busy_o, 0);
    feat_i = f;
    wgt_i = w;
    lane_msk_i = m;
    feat_signed_i = sg;
    last_i = lst;
    set_vld(1'b1);
    @(posedge clk); #1;
    set_vld(1'b0);
    last_i = 1'b0;
    raw = m_acc + beat_sum(f, w, m, sg);
    m_acc = clamp(raw, AW);
    if (m_acc != raw) m_sat = 1;
    if (lst) begin
      o = clamp(m_acc, OW);
      sb.push_back('{o, m_sat | (o != m_acc)});
    end
  endtask

  task automatic wait_result(input int hold);
    int   n;
    exp_t e;
    n = 0;
    check("busy_after_last", busy_o, 1);
    check("vld_not_early", out_vld_o, 0);
    while (out_vld_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, 1);
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    check("out_data", signed'(out_data_o), e.data);
    check("sat_flag", sat_flag_o, e.sat);
    check("busy_hold", busy_o, 1);
    for (int i = 0; i < hold; i++) begin
      feat_i = {4{8'd9}};
      wgt_i = {4{8'd9}};
      lane_msk_i = 4'hf;
      last_i = 1'b1;
      set_vld(1'b1);
      @(posedge clk); #1;
      check("hold_data", signed'(out_data_o), e.data);
      check("hold_vld", out_vld_o, 1);
      check("hold_busy", busy_o, 1);
    end
    set_vld(1'b0);
    last_i = 1'b0;
    out_rdy_i = 1'b1;
    @(posedge clk); #1;
    out_rdy_i = 1'b0;
    check("vld_after_hs", out_vld_o, 0);
    check("busy_after_hs", busy_o, 0);
    check("sat_kept", sat_flag_o, e.sat);
    m_acc = 0;
    m_sat = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    check("rst_data", out_data_o, 0);
    check("rst_vld", out_vld_o, 0);
    check("rst_sat", sat_flag_o, 0);
    check("rst_busy", busy_o, 0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    // four back-to-back beats: 2*(1+2+3+4)*4 = 80
    do_clr(0);
    for (int k = 1; k <= 4; k++) send({4{8'(k)}}, {4{8'd2}}, 4'hf, 1'b1, k == 4);
    wait_result(0);

    // unsigned vs signed feature lane 0 = 0xFF
    do_clr(0);
    send(32'h0000_00FF, {4{8'd1}}, 4'b0001, 1'b0, 1'b1);
    wait_result(0);
    send(32'h0000_00FF, {4{8'd1}}, 4'b0001, 1'b1, 1'b1);
    wait_result(0);

    // bias and masking: -10 + 2*15 = 20
    do_clr(-10);
    send({4{8'd3}}, {4{8'd5}}, 4'b0101, 1'b1, 1'b1);
    wait_result(0);

    // positive output clip with back-pressure, then a fresh tile from zero
    do_clr((longint'(1) << 17) - 5);
    send({4{8'd25}}, {4{8'd1}}, 4'hf, 1'b1, 1'b1);
    wait_result(5);
    send({4{8'd1}}, {4{8'd1}}, 4'hf, 1'b1, 1'b1);
    wait_result(0);

    // negative output clip
    do_clr(-(longint'(1) << 17) + 5);
    send({4{8'd25}}, {4{8'hFF}}, 4'hf, 1'b1, 1'b1);
    wait_result(0);

    // clear on the same cycle as a valid last beat: beat dropped, acc = 7
    clr_i = 1'b1;
    bias_i = 24'd7;
    feat_i = {4{8'd1}};
    wgt_i = {4{8'd1}};
    lane_msk_i = 4'hf;
    last_i = 1'b1;
    set_vld(1'b1);
    @(posedge clk); #1;
    clr_i = 1'b0;
    set_vld(1'b0);
    last_i = 1'b0;
    m_acc = 7;
    m_sat = 0;
    check("clr_beat_busy", busy_o, 0);
    @(posedge clk); #1;
    check("clr_beat_vld", out_vld_o, 0);
    send({4{8'd1}}, {4{8'd1}}, 4'hf, 1'b1, 1'b1);
    wait_result(0);

    // clear while in HOLD with a simultaneous ready: result discarded, acc = 3
    send({4{8'd1}}, {4{8'd1}}, 4'hf, 1'b1, 1'b1);
    n = 0;
    while (out_vld_o !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("hold_clr_vld_up", out_vld_o, 1);
    clr_i = 1'b1;
    bias_i = 24'd3;
    out_rdy_i = 1'b1;
    @(posedge clk); #1;
    clr_i = 1'b0;
    out_rdy_i = 1'b0;
    check("hold_clr_vld", out_vld_o, 0);
    check("hold_clr_sat", sat_flag_o, 0);
    check("hold_clr_busy", busy_o, 0);
    if (sb.size() > 0) void'(sb.pop_front());
    m_acc = 3;
    m_sat = 0;
    send({4{8'd1}}, {4{8'd1}}, 4'hf, 1'b1, 1'b1);
    wait_result(0);

    // asynchronous reset mid-tile clears everything
    send({4{8'd50}}, {4{8'd1}}, 4'hf, 1'b1, 1'b0);
    rstn = 1'b0;
    #1;
    check("midrst_data", out_data_o, 0);
    check("midrst_vld", out_vld_o, 0);
    check("midrst_sat", sat_flag_o, 0);
    check("midrst_busy", busy_o, 0);
    @(posedge clk); #1;
    rstn = 1'b1;
    m_acc = 0;
    m_sat = 0;
    send({4{8'd2}}, {4{8'd3}}, 4'hf, 1'b1, 1'b1);
    wait_result(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
